// File: rtl/fp_pkg.sv
// fp_pkg: shared field widths, constants, state encoding and field helpers
// for the sequential single-precision subtractor.
package fp_pkg;
   localparam int W = 32;
   localparam int EXP_W = 8;
   localparam int MAN_W = 23;
   localparam int SIG_W = 28;
   localparam int EXP_BIAS = 127;
   localparam logic [EXP_W-1:0] EXP_MAX = EXP_W'(2 * EXP_BIAS + 1);
   localparam logic [W-1:0] QNAN = 32'h7FC00000;

   typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, DONE} state_t;

   function automatic logic f_sign(input logic [W-1:0] x);
      return x[W-1];
   endfunction

   function automatic logic [EXP_W-1:0] f_exp(input logic [W-1:0] x);
      return x[W-2:MAN_W];
   endfunction

   function automatic logic [MAN_W-1:0] f_frac(input logic [W-1:0] x);
      return x[MAN_W-1:0];
   endfunction

   function automatic logic [W-1:0] f_pack(input logic s, input logic [EXP_W-1:0] e,
                                          input logic [MAN_W-1:0] m);
      return {s, e, m};
   endfunction
endpackage

// File: rtl/fp_unpack.sv
// fp_unpack: splits a float into sign/exponent/28-bit working significand,
// flushing denormals to zero and flagging exp==255 operands.
module fp_unpack
   import fp_pkg::*;
(
   input  logic [W-1:0]     x,
   output logic             sign,
   output logic [EXP_W-1:0] ex,
   output logic [SIG_W-1:0] sig,
   output logic             special
);
   logic [EXP_W-1:0] e;
   logic             z;
   always_comb begin
      e = f_exp(x);
      z = e == '0;
      sign = f_sign(x);
      ex = z ? '0 : e;
      sig = z ? '0 : {2'b01, f_frac(x), 3'b000};
      special = e == EXP_MAX;
   end
endmodule

// File: rtl/fp_subtractor_seq.sv
// fp_subtractor_seq: iterative diff = a - b, aligning and normalising one bit
// per cycle behind a start/done handshake.
module fp_subtractor_seq
   import fp_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] diff,
   output logic         invalid
);
   localparam logic [EXP_W-1:0] ALIGN_MAX = EXP_W'(SIG_W - 2);

   state_t state, state_nx;
   logic [W-1:0]     a_r, b_r;
   logic             sa, sb, xa, xb, swap;
   logic [EXP_W-1:0] ea, eb, exp_r, d_r;
   logic [SIG_W-1:0] ga, gb, sig_l, sig_s;
   logic             sign_l, sign_s;
   logic             n_zero, n_carry, n_ok, n_under, n_over;

   fp_unpack u_a (.x(a_r), .sign(sa), .ex(ea), .sig(ga), .special(xa));
   fp_unpack u_b (.x(b_r), .sign(sb), .ex(eb), .sig(gb), .special(xb));

   assign swap = {eb, gb} > {ea, ga};
   assign busy = state != IDLE;
   assign done = state == DONE;

   always_comb begin
      n_zero = sig_l == '0;
      n_carry = sig_l[SIG_W-1];
      n_ok = !n_carry && sig_l[SIG_W-2];
      n_under = !n_zero && !n_carry && !sig_l[SIG_W-2] && exp_r == 8'd1;
      n_over = n_carry && exp_r == EXP_MAX - 8'd1;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = start ? UNPACK : IDLE;
         UNPACK:  state_nx = (xa || xb) ? DONE : ALIGN;
         ALIGN:   state_nx = d_r == '0 ? ADD : ALIGN;
         ADD:     state_nx = NORM;
         NORM:    state_nx = (n_zero || n_under || n_over || n_ok) ? DONE : NORM;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         a_r <= '0;
         b_r <= '0;
         diff <= '0;
         invalid <= 1'b0;
         sign_l <= 1'b0;
         sign_s <= 1'b0;
         exp_r <= '0;
         d_r <= '0;
         sig_l <= '0;
         sig_s <= '0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: if (start) begin
               a_r <= a;
               b_r <= {~b[W-1], b[W-2:0]};
               invalid <= 1'b0;
            end
            UNPACK: begin
               if (xa || xb) begin
                  diff <= QNAN;
                  invalid <= 1'b1;
               end
               sign_l <= swap ? sb : sa;
               sign_s <= swap ? sa : sb;
               exp_r <= swap ? eb : ea;
               d_r <= swap ? eb - ea : ea - eb;
               sig_l <= swap ? gb : ga;
               sig_s <= swap ? ga : gb;
            end
            ALIGN: if (d_r != '0) begin
               sig_s <= d_r > ALIGN_MAX ? '0 : sig_s >> 1;
               d_r <= d_r > ALIGN_MAX ? '0 : d_r - 8'd1;
            end
            ADD: sig_l <= sign_l == sign_s ? sig_l + sig_s : sig_l - sig_s;
            NORM: begin
               // Packing happens on the way into DONE so diff is valid with the pulse.
               if (n_zero || n_under)
                  diff <= '0;
               else if (n_over)
                  diff <= f_pack(sign_l, EXP_MAX, '0);
               else if (n_ok)
                  diff <= f_pack(sign_l, exp_r, sig_l[SIG_W-3:3]);
               else if (n_carry) begin
                  sig_l <= sig_l >> 1;
                  exp_r <= exp_r + 8'd1;
               end else begin
                  sig_l <= sig_l << 1;
                  exp_r <= exp_r - 8'd1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_fp_subtractor_seq.sv
// tb_fp_subtractor_seq: directed table, handshake corner sequences and random
// operands checked against an arithmetic reference of the subtraction rules.
module tb_fp_subtractor_seq;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [31:0] a = '0, b = '0;
   logic        busy, done, invalid;
   logic [31:0] diff;
   int          total = 0, bad = 0;

   typedef struct {
      string       name;
      logic [31:0] a, b, d;
      logic        inv;
   } vec_t;

   fp_subtractor_seq dut (.clk(clk), .rst(rst), .start(start), .a(a), .b(b),
                          .busy(busy), .done(done), .diff(diff), .invalid(invalid));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h", nm, got, want);
      end
   endtask

   // Truncating subtract: align by plain shift, cancel, then find the leading one.
   function automatic logic [31:0] ref_sub(input logic [31:0] x, input logic [31:0] y);
      int ex, ey, el, es, e, d;
      longint mx, my, ml, ms, r;
      bit sx, sy, sl, ss;
      ex = x[30:23];
      ey = y[30:23];
      if (ex == 255 || ey == 255) return 32'h7FC00000;
      mx = ex == 0 ? 0 : longint'({1'b1, x[22:0]}) << 3;
      my = ey == 0 ? 0 : longint'({1'b1, y[22:0]}) << 3;
      sx = x[31];
      sy = ~y[31];
      if (ey > ex || (ey == ex && my > mx)) begin
         el = ey; ml = my; sl = sy; es = ex; ms = mx; ss = sx;
      end else begin
         el = ex; ml = mx; sl = sx; es = ey; ms = my; ss = sy;
      end
      d = el - es;
      ms = d > 40 ? 0 : ms >> d;
      r = sl == ss ? ml + ms : ml - ms;
      if (r == 0) return 32'h0;
      if (r >= (64'd1 << 27)) begin
         r = r >> 1;
         e = el + 1;
         if (e >= 255) return {sl, 8'hFF, 23'h0};
      end else begin
         e = el;
         while (r < (64'd1 << 26)) begin
            r = r << 1;
            e--;
         end
         if (e <= 0) return 32'h0;
      end
      return {sl, 8'(e), r[25:3]};
   endfunction

   task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_v,
                        output logic [31:0] rd, output logic ri);
      int n;
      @(negedge clk);
      a = ta;
      b = tb_v;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a = $urandom;
      b = $urandom;
      n = 1;
      while (!done && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk("done_seen", {31'b0, done}, 32'd1);
      rd = diff;
      ri = invalid;
      chk("latency_max", {31'b0, n <= 52}, 32'd1);
      if (!ri) chk("latency_min", {31'b0, n >= 4}, 32'd1);
      @(negedge clk);
      chk("done_single", {31'b0, done}, 32'd0);
      chk("idle_after", {31'b0, busy}, 32'd0);
   endtask

   initial begin
      vec_t tbl[10];
      logic [31:0] rd, ra, rb;
      logic ri;
      tbl[0] = '{"3_minus_1",    32'h40400000, 32'h3F800000, 32'h40000000, 1'b0};
      tbl[1] = '{"1_minus_1",    32'h3F800000, 32'h3F800000, 32'h00000000, 1'b0};
      tbl[2] = '{"neg_half_6",   32'hBF000000, 32'h40C00000, 32'hC0D00000, 1'b0};
      tbl[3] = '{"carry_norm",   32'h41200000, 32'hC1200000, 32'h41A00000, 1'b0};
      tbl[4] = '{"guard_left",   32'h4B800000, 32'h3F800000, 32'h4B7FFFFF, 1'b0};
      tbl[5] = '{"b_inf",        32'h3F800000, 32'h7F800000, 32'h7FC00000, 1'b1};
      tbl[6] = '{"clear_inv",    32'h40400000, 32'h3F800000, 32'h40000000, 1'b0};
      tbl[7] = '{"overflow_inf", 32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 1'b0};
      tbl[8] = '{"underflow",    32'h00800000, 32'h00800001, 32'h00000000, 1'b0};
      tbl[9] = '{"denorm_flush", 32'h00000001, 32'h3F800000, 32'hBF800000, 1'b0};

      #1;
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_diff", diff, 32'd0);
      chk("rst_inv", {31'b0, invalid}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         do_op(tbl[i].a, tbl[i].b, rd, ri);
         chk({tbl[i].name, "_diff"}, rd, tbl[i].d);
         chk({tbl[i].name, "_inv"}, {31'b0, ri}, {31'b0, tbl[i].inv});
      end

      // start pulses while busy and during the done cycle must be ignored
      @(negedge clk);
      a = 32'h40400000;
      b = 32'h3F800000;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      a = 32'hC2000000;
      b = 32'h41000000;
      start = 1'b1;
      repeat (2) @(negedge clk);
      start = 1'b0;
      for (int n = 0; n < 60 && !done; n++) @(negedge clk);
      chk("busy_ign_done", {31'b0, done}, 32'd1);
      chk("busy_ign_diff", diff, 32'h40000000);
      start = 1'b1;
      @(negedge clk);
      chk("done_ign_busy", {31'b0, busy}, 32'd0);
      chk("done_ign_diff", diff, 32'h40000000);
      start = 1'b0;

      // async reset in the middle of a long alignment
      @(negedge clk);
      a = 32'h4B800000;
      b = 32'h3F800000;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst_busy", {31'b0, busy}, 32'd0);
      chk("midrst_diff", diff, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      do_op(32'h4B800000, 32'h3F800000, rd, ri);
      chk("after_rst_diff", rd, 32'h4B7FFFFF);

      for (int i = 0; i < 150; i++) begin
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 3))
            0: rb[30:23] = ra[30:23];
            1: rb[30:23] = ra[30:23] - 8'($urandom_range(0, 3));
            2: rb = {1'($urandom), ra[30:0]};
            default: ;
         endcase
         do_op(ra, rb, rd, ri);
         chk("rand_diff", rd, ref_sub(ra, rb));
         chk("rand_inv", {31'b0, ri}, {31'b0, ra[30:23] == 8'hFF || rb[30:23] == 8'hFF});
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
